// File: rtl/triangle_submit_arbiter_pkg.sv
// Shared constants for the triangle submit path: record layout and arbiter state encoding.
`default_nettype none

package triangle_submit_arbiter_pkg;

    localparam int VERTEX_W = 288;

    // 32-bit fields inside one triangle record.
    localparam int OFF_A_X   = 0;
    localparam int OFF_A_Y   = 32;
    localparam int OFF_B_X   = 64;
    localparam int OFF_B_Y   = 96;
    localparam int OFF_C_X   = 128;
    localparam int OFF_C_Y   = 160;
    localparam int OFF_COL_A = 192;
    localparam int OFF_COL_B = 224;
    localparam int OFF_COL_C = 256;
    localparam int FIELD_W   = 32;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/triangle_submit_arbiter_if.sv
// Requester bundle plus vertex-FIFO write side, shared by the arbiter and its sources.
`default_nettype none

interface triangle_submit_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 288
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         vertex_data;
    logic                      vertex_data_valid;
    logic                      vertex_data_full;

    modport master (
        output req_valid, req_last, req_data, vertex_data_full,
        input  req_ready, vertex_data, vertex_data_valid
    );

    modport slave (
        input  req_valid, req_last, req_data, vertex_data_full,
        output req_ready, vertex_data, vertex_data_valid
    );
endinterface

`default_nettype wire

// File: rtl/triangle_submit_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
`default_nettype none

module triangle_submit_arbiter_rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  wire logic [NUM_REQ-1:0] req_i,
    input  wire logic [1:0]         last_i,
    output logic [NUM_REQ-1:0]      oh_o,
    output logic [1:0]              idx_o,
    output logic                    any_o
);

    always_comb begin
        oh_o  = '0;
        idx_o = '0;
        any_o = 1'b0;
        // Offset k=NUM_REQ wraps back to last_i itself, so it is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any_o && req_i[j] && (((int'(last_i) + k) % NUM_REQ) == j)) begin
                    any_o   = 1'b1;
                    idx_o   = 2'(j);
                    oh_o[j] = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/triangle_submit_arbiter.sv
// Round-robin, burst-locked arbiter feeding the rasteriser vertex FIFO at <= 1 write / 2 cycles.
`default_nettype none

module triangle_submit_arbiter
    import triangle_submit_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = VERTEX_W,
    parameter int MAX_BURST = 64
) (
    input  wire logic                clock,
    input  wire logic                reset_n,
    input  wire logic                enable_i,
    triangle_submit_arbiter_if.slave bus,
    output logic                     grant_valid_o,
    output logic [1:0]               grant_id_o,
    output logic [31:0]              tri_count_o
);

    localparam logic [15:0] MAX_BURST_C = 16'(MAX_BURST);

    arb_state_e          state_q, state_d;
    logic [1:0]          grant_id_q, grant_id_d;
    logic [1:0]          last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]  grant_oh_q, grant_oh_d;
    logic [15:0]         burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0]   vdata_q, vdata_d;
    logic                vvalid_q, vvalid_d;
    logic [31:0]         tri_count_q, tri_count_d;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [1:0]          pick_idx;
    logic                pick_any;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_valid;
    logic                sel_last;
    logic                ready_g;
    logic                xfer;
    logic                burst_done;

    triangle_submit_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i  (bus.req_valid),
        .last_i (last_grant_q),
        .oh_o   (pick_oh),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_oh_q[j]) begin
                sel_data = sel_data | bus.req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_valid = |(bus.req_valid & grant_oh_q);
    assign sel_last  = |(bus.req_last & grant_oh_q);

    // Blocking the cycle after a strobe covers the FIFO's one-cycle-late full flag.
    assign ready_g    = (state_q == ST_LOCKED) && !bus.vertex_data_full && !vvalid_q;
    assign xfer       = ready_g && sel_valid;
    assign burst_done = (burst_cnt_q + 16'd1) == MAX_BURST_C;

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        grant_oh_d   = grant_oh_q;
        burst_cnt_d  = burst_cnt_q;
        vdata_d      = vdata_q;
        vvalid_d     = 1'b0;
        tri_count_d  = tri_count_q;

        if (xfer) begin
            vdata_d     = sel_data;
            vvalid_d    = 1'b1;
            tri_count_d = tri_count_q + 32'd1;
            burst_cnt_d = burst_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable_i && pick_any) begin
                    grant_id_d  = pick_idx;
                    grant_oh_d  = pick_oh;
                    burst_cnt_d = '0;
                    state_d     = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (xfer && (sel_last || burst_done)) begin
                    last_grant_d = grant_id_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= 2'(NUM_REQ - 1);
            grant_oh_q   <= '0;
            burst_cnt_q  <= '0;
            vdata_q      <= '0;
            vvalid_q     <= 1'b0;
            tri_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            grant_oh_q   <= grant_oh_d;
            burst_cnt_q  <= burst_cnt_d;
            vdata_q      <= vdata_d;
            vvalid_q     <= vvalid_d;
            tri_count_q  <= tri_count_d;
        end
    end

    assign bus.req_ready         = grant_oh_q & {NUM_REQ{ready_g}};
    assign bus.vertex_data       = vdata_q;
    assign bus.vertex_data_valid = vvalid_q;
    assign grant_valid_o         = (state_q == ST_LOCKED);
    assign grant_id_o            = grant_id_q;
    assign tri_count_o           = tri_count_q;

endmodule

`default_nettype wire

// File: tb/tb_triangle_submit_arbiter.sv
// Directed self-checking bench for triangle_submit_arbiter (NUM_REQ=2, MAX_BURST=4).
`default_nettype none

module tb_triangle_submit_arbiter;

    localparam int NR = 2;
    localparam int DW = 288;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [31:0] tri_count;

    int n_checks = 0;
    int n_fail   = 0;

    triangle_submit_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    triangle_submit_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .MAX_BURST (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable_i      (enable),
        .bus           (bus.slave),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id),
        .tri_count_o   (tri_count)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mk(input logic [31:0] s);
        return {9{s}};
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid        = '0;
        bus.req_last         = '0;
        bus.req_data         = '0;
        bus.vertex_data_full = 1'b0;
        enable               = 1'b1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (3) tick();
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_grant_valid got %b want 0", grant_valid); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b want 00", bus.req_ready); end
        n_checks++; if (bus.vertex_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vvalid got %b want 0", bus.vertex_data_valid); end
        n_checks++; if (bus.vertex_data !== '0) begin n_fail++; $display("FAIL reset_vdata got %h want 0", bus.vertex_data); end
        n_checks++; if (tri_count !== 32'd0) begin n_fail++; $display("FAIL reset_tri_count got %0d want 0", tri_count); end
        reset_n = 1'b1;
        tick();
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_req_grant got %b want 0", grant_valid); end
    endtask

    task automatic test_single_burst();
        do_reset();
        bus.req_valid = 2'b01;
        bus.req_data[0 +: DW] = mk(32'hA000_0000);
        tick(); // cycle 1
        n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL sb_grant c1 got v=%b id=%0d want v=1 id=0", grant_valid, grant_id); end
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL sb_ready c1 got %b want 01", bus.req_ready); end
        tick(); // cycle 2
        n_checks++; if (bus.vertex_data_valid !== 1'b1 || bus.vertex_data !== mk(32'hA000_0000)) begin n_fail++; $display("FAIL sb_strobe c2 got v=%b d=%h", bus.vertex_data_valid, bus.vertex_data); end
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL sb_ready c2 got %b want 00", bus.req_ready); end
        n_checks++; if (tri_count !== 32'd1) begin n_fail++; $display("FAIL sb_tri c2 got %0d want 1", tri_count); end
        bus.req_data[0 +: DW] = mk(32'hA000_0001);
        tick(); // cycle 3
        n_checks++; if (bus.vertex_data_valid !== 1'b0 || bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL sb_c3 got v=%b rdy=%b want v=0 rdy=01", bus.vertex_data_valid, bus.req_ready); end
        tick(); // cycle 4
        n_checks++; if (bus.vertex_data_valid !== 1'b1 || bus.vertex_data !== mk(32'hA000_0001)) begin n_fail++; $display("FAIL sb_strobe c4 got v=%b d=%h", bus.vertex_data_valid, bus.vertex_data); end
        bus.req_data[0 +: DW] = mk(32'hA000_0002);
        bus.req_last = 2'b01;
        tick(); // cycle 5
        n_checks++; if (bus.vertex_data_valid !== 1'b0) begin n_fail++; $display("FAIL sb_c5_vvalid got %b want 0", bus.vertex_data_valid); end
        tick(); // cycle 6
        n_checks++; if (bus.vertex_data_valid !== 1'b1 || bus.vertex_data !== mk(32'hA000_0002)) begin n_fail++; $display("FAIL sb_strobe c6 got v=%b d=%h", bus.vertex_data_valid, bus.vertex_data); end
        n_checks++; if (tri_count !== 32'd3) begin n_fail++; $display("FAIL sb_tri c6 got %0d want 3", tri_count); end
        bus.req_valid = '0;
        bus.req_last  = '0;
        tick(); // cycle 7
        n_checks++; if (grant_valid !== 1'b0 || bus.vertex_data_valid !== 1'b0) begin n_fail++; $display("FAIL sb_c7 got gv=%b v=%b want 0 0", grant_valid, bus.vertex_data_valid); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp_d;
        logic [1:0]    exp_id;
        do_reset();
        bus.req_valid = 2'b11;
        bus.req_last  = 2'b11;
        bus.req_data[0  +: DW] = mk(32'hB000_0000);
        bus.req_data[DW +: DW] = mk(32'hB111_1111);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (cyc == 8) bus.req_valid = '0;
            if (cyc % 2 == 1) begin
                exp_id = 2'(((cyc - 1) / 2) % 2);
                n_checks++; if (grant_valid !== 1'b1 || grant_id !== exp_id) begin n_fail++; $display("FAIL rr_grant c%0d got v=%b id=%0d want v=1 id=%0d", cyc, grant_valid, grant_id, exp_id); end
                n_checks++; if (bus.vertex_data_valid !== 1'b0) begin n_fail++; $display("FAIL rr_vvalid c%0d got %b want 0", cyc, bus.vertex_data_valid); end
            end else begin
                exp_d = (((cyc / 2) - 1) % 2 == 0) ? mk(32'hB000_0000) : mk(32'hB111_1111);
                n_checks++; if (bus.vertex_data_valid !== 1'b1 || bus.vertex_data !== exp_d) begin n_fail++; $display("FAIL rr_strobe c%0d got v=%b d=%h want d=%h", cyc, bus.vertex_data_valid, bus.vertex_data, exp_d); end
            end
        end
        n_checks++; if (tri_count !== 32'd4) begin n_fail++; $display("FAIL rr_tri got %0d want 4", tri_count); end
        tick();
    endtask

    task automatic test_full_backpressure();
        do_reset();
        bus.req_valid = 2'b01;
        bus.req_data[0 +: DW] = mk(32'hC000_0000);
        tick(); // cycle 1
        tick(); // cycle 2
        n_checks++; if (bus.vertex_data_valid !== 1'b1 || bus.vertex_data !== mk(32'hC000_0000)) begin n_fail++; $display("FAIL bp_first got v=%b d=%h", bus.vertex_data_valid, bus.vertex_data); end
        bus.vertex_data_full = 1'b1;
        bus.req_data[0 +: DW] = mk(32'hC000_0001);
        for (int cyc = 3; cyc <= 11; cyc++) begin
            tick();
            n_checks++; if (bus.vertex_data_valid !== 1'b0 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_hold c%0d got v=%b rdy=%b want 0 00", cyc, bus.vertex_data_valid, bus.req_ready); end
        end
        tick(); // cycle 12
        bus.vertex_data_full = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_resume_ready got %b want 01", bus.req_ready); end
        tick(); // cycle 13
        n_checks++; if (bus.vertex_data_valid !== 1'b1 || bus.vertex_data !== mk(32'hC000_0001)) begin n_fail++; $display("FAIL bp_resume_strobe got v=%b d=%h", bus.vertex_data_valid, bus.vertex_data); end
        bus.req_data[0 +: DW] = mk(32'hC000_0002);
        bus.req_last = 2'b01;
        tick(); // cycle 14
        tick(); // cycle 15
        n_checks++; if (bus.vertex_data_valid !== 1'b1 || grant_valid !== 1'b0 || tri_count !== 32'd3) begin n_fail++; $display("FAIL bp_end got v=%b gv=%b tri=%0d want 1 0 3", bus.vertex_data_valid, grant_valid, tri_count); end
        clear_inputs();
        tick();
    endtask

    task automatic test_max_burst();
        logic exp_v, exp_gv;
        logic [DW-1:0] exp_d;
        do_reset();
        bus.req_valid = 2'b11;
        bus.req_last  = 2'b10;
        bus.req_data[0  +: DW] = mk(32'hD000_0000);
        bus.req_data[DW +: DW] = mk(32'hD111_1111);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            if (cyc == 10) bus.req_valid = '0;
            exp_v  = (cyc % 2 == 0);
            exp_gv = (cyc <= 7) || (cyc == 9);
            n_checks++; if (bus.vertex_data_valid !== exp_v || grant_valid !== exp_gv) begin n_fail++; $display("FAIL mb c%0d got v=%b gv=%b want v=%b gv=%b", cyc, bus.vertex_data_valid, grant_valid, exp_v, exp_gv); end
            if (exp_gv) begin
                n_checks++; if (grant_id !== ((cyc < 8) ? 2'd0 : 2'd1)) begin n_fail++; $display("FAIL mb_id c%0d got %0d", cyc, grant_id); end
            end
            if (exp_v) begin
                exp_d = (cyc < 10) ? mk(32'hD000_0000) : mk(32'hD111_1111);
                n_checks++; if (bus.vertex_data !== exp_d) begin n_fail++; $display("FAIL mb_data c%0d got %h want %h", cyc, bus.vertex_data, exp_d); end
            end
        end
        n_checks++; if (tri_count !== 32'd5) begin n_fail++; $display("FAIL mb_tri got %0d want 5", tri_count); end
        clear_inputs();
        tick();
    endtask

    task automatic test_disable_and_reset();
        do_reset();
        bus.req_valid = 2'b01;
        bus.req_data[0 +: DW] = mk(32'hE000_0000);
        tick(); // cycle 1
        enable = 1'b0;
        tick(); // cycle 2
        n_checks++; if (bus.vertex_data_valid !== 1'b1) begin n_fail++; $display("FAIL dis_first_strobe got %b want 1", bus.vertex_data_valid); end
        bus.req_data[0 +: DW] = mk(32'hE000_0001);
        bus.req_last = 2'b01;
        tick(); // cycle 3
        tick(); // cycle 4
        n_checks++; if (bus.vertex_data_valid !== 1'b1 || bus.vertex_data !== mk(32'hE000_0001) || grant_valid !== 1'b0) begin n_fail++; $display("FAIL dis_burst_done got v=%b gv=%b d=%h", bus.vertex_data_valid, grant_valid, bus.vertex_data); end
        bus.req_valid = 2'b11;
        bus.req_last  = 2'b00;
        bus.req_data[DW +: DW] = mk(32'hE111_1111);
        for (int cyc = 5; cyc <= 9; cyc++) begin
            tick();
            n_checks++; if (grant_valid !== 1'b0 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL dis_no_grant c%0d got gv=%b rdy=%b", cyc, grant_valid, bus.req_ready); end
        end
        n_checks++; if (tri_count !== 32'd2) begin n_fail++; $display("FAIL dis_tri got %0d want 2", tri_count); end
        enable = 1'b1;
        tick(); // cycle 10: first cycle of a new grant
        n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1 || bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL en_regrant got gv=%b id=%0d rdy=%b want 1 1 10", grant_valid, grant_id, bus.req_ready); end
        reset_n = 1'b0;
        tick(); // cycle 11
        n_checks++; if (bus.vertex_data_valid !== 1'b0 || grant_valid !== 1'b0 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_mid_ctrl got v=%b gv=%b rdy=%b want 0 0 00", bus.vertex_data_valid, grant_valid, bus.req_ready); end
        n_checks++; if (tri_count !== 32'd0 || grant_id !== 2'd0 || bus.vertex_data !== '0) begin n_fail++; $display("FAIL rst_mid_data got tri=%0d id=%0d d=%h want 0", tri_count, grant_id, bus.vertex_data); end
        clear_inputs();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_backpressure();
        test_max_burst();
        test_disable_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
